dmem_responder: RTL and testbench

- Single-port data-memory responder: the memory end of the CPU's data-memory request/response handshake.
- Accepts word-addressed read and write requests with per-byte write enables from the load/store datapath.
- Answers each request with a single-cycle mem_resp after a fixed, parameterised latency.
- Used as the data memory in simulation and small FPGA builds; the CPU multicycle FSM stalls on mem_resp.

---
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-port data memory answering CPU load/store requests; `define DMEM_ERR_EN adds mem_err reporting.
// mem_resp pulses LATENCY cycles after acceptance, one cycle wide; the initiator holds its request and stalls until then.
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] mem_address,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_byte_enable,
  output logic        mem_resp,
  output logic [31:0] mem_rdata
`ifdef DMEM_ERR_EN
  ,
  output logic        mem_err
`endif
);
  localparam int         AW       = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t        state, state_nxt;
  logic [3:0]    cnt, cnt_nxt;
  logic          accept, enter_resp;

  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic          wr_q;
  logic          err_q;

  logic [31:0]   mem [DEPTH_WORDS];

  logic          req, req_err, in_idle;
  logic [AW-1:0] idx_eff;
  logic [31:0]   wdata_eff;
  logic [3:0]    be_eff;
  logic          wr_eff, err_eff;
  logic          unused_addr;

  assign req     = mem_read | mem_write;
  assign in_idle = (state == IDLE);

`ifdef DMEM_ERR_EN
  assign req_err = (mem_address[31:AW+2] != '0) || (mem_read && mem_write);
`else
  assign req_err = 1'b0;
`endif

  assign unused_addr = ^{mem_address[31:AW+2], mem_address[1:0]};

  // With LATENCY=1 the array is touched on the accepting edge, so the live inputs stand in for the capture.
  assign idx_eff   = in_idle ? mem_address[AW+1:2] : idx_q;
  assign wdata_eff = in_idle ? mem_wdata           : wdata_q;
  assign be_eff    = in_idle ? mem_byte_enable     : be_q;
  assign wr_eff    = in_idle ? mem_write           : wr_q;
  assign err_eff   = in_idle ? req_err             : err_q;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    accept     = 1'b0;
    enter_resp = 1'b0;
    mem_resp   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (LATENCY == 1) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        mem_resp  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else if (accept) begin
      idx_q   <= mem_address[AW+1:2];
      wdata_q <= mem_wdata;
      be_q    <= mem_byte_enable;
      wr_q    <= mem_write;
      err_q   <= req_err;
    end
  end

  // rst_n gate keeps a request seen during reset from landing in the array.
  always_ff @(posedge clk) begin
    if (rst_n && enter_resp && wr_eff && !err_eff) begin
      for (int i = 0; i < 4; i++) begin
        if (be_eff[i]) mem[idx_eff][8*i +: 8] <= wdata_eff[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rdata <= 32'd0;
    end else if (enter_resp && !wr_eff) begin
      mem_rdata <= err_eff ? 32'hDEAD_BEEF : mem[idx_eff];
    end
  end

`ifdef DMEM_ERR_EN
  assign mem_err = mem_resp & err_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: one LATENCY=2 instance and one LATENCY=1 instance.
module tb_dmem_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_read = 1'b0, a_write = 1'b0, a_resp, a_err;
  logic [31:0] a_addr = '0, a_wdata = '0, a_rdata;
  logic [3:0]  a_be = '0;
  logic        b_read = 1'b0, b_write = 1'b0, b_resp, b_err;
  logic [31:0] b_addr = '0, b_wdata = '0, b_rdata;
  logic [3:0]  b_be = '0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_dut_l2 (
    .clk(clk), .rst_n(rst_n), .mem_read(a_read), .mem_write(a_write),
    .mem_address(a_addr), .mem_wdata(a_wdata), .mem_byte_enable(a_be),
    .mem_resp(a_resp), .mem_rdata(a_rdata)
`ifdef DMEM_ERR_EN
    , .mem_err(a_err)
`endif
  );

  dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_dut_l1 (
    .clk(clk), .rst_n(rst_n), .mem_read(b_read), .mem_write(b_write),
    .mem_address(b_addr), .mem_wdata(b_wdata), .mem_byte_enable(b_be),
    .mem_resp(b_resp), .mem_rdata(b_rdata)
`ifdef DMEM_ERR_EN
    , .mem_err(b_err)
`endif
  );

`ifndef DMEM_ERR_EN
  assign a_err = 1'b0;
  assign b_err = 1'b0;
`endif

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic set_in(input bit u1, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be);
    if (u1) begin
      b_read = rd; b_write = wr; b_addr = addr; b_wdata = wd; b_be = be;
    end else begin
      a_read = rd; a_write = wr; a_addr = addr; a_wdata = wd; a_be = be;
    end
  endtask

  // Called #1 after a rising edge (cycle 0). Returns the cycle mem_resp was seen,
  // the read data and mem_err in that cycle, and mem_resp one cycle later.
  task automatic run_op(input bit u1, input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] addr_wait, input logic [31:0] wd, input logic [3:0] be,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic resp_after);
    logic resp;
    set_in(u1, rd, wr, addr, wd, be);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) set_in(u1, rd, wr, addr_wait, ~wd, ~be);
      resp = u1 ? b_resp : a_resp;
    end while (!resp && lat < 20);
    rdata = u1 ? b_rdata : a_rdata;
    err   = u1 ? b_err : a_err;
    set_in(u1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    resp_after = u1 ? b_resp : a_resp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    logic        err, ra;

    repeat (2) @(posedge clk);
    #1;
    chk_val("rst_resp", 32'(a_resp), 32'd0);
    chk_val("rst_rdata", a_rdata, 32'd0);
    chk_val("rst_resp_l1", 32'(b_resp), 32'd0);
    rst_n = 1'b1;

    run_op(0, 0, 1, 32'h10, 32'h10, 32'h1234_5678, 4'hF, lat, rd, err, ra);
    chk_val("wr_lat", 32'(lat), 32'd2);
    chk_val("wr_pulse_width", 32'(ra), 32'd0);
    chk_val("wr_err", 32'(err), 32'd0);
    run_op(0, 1, 0, 32'h10, 32'h10, 32'h0, 4'h0, lat, rd, err, ra);
    chk_val("rd_b2b_lat", 32'(lat), 32'd2);
    chk_val("rd_data", rd, 32'h1234_5678);

    run_op(0, 0, 1, 32'h10, 32'h10, 32'hAABB_CCDD, 4'b0101, lat, rd, err, ra);
    chk_val("wr_keeps_rdata", rd, 32'h1234_5678);
    run_op(0, 1, 0, 32'h10, 32'h10, 32'h0, 4'h0, lat, rd, err, ra);
    chk_val("rd_lanes", rd, 32'h12BB_56DD);

    run_op(0, 0, 1, 32'h10, 32'h10, 32'hFFFF_FFFF, 4'b0000, lat, rd, err, ra);
    chk_val("be0_lat", 32'(lat), 32'd2);
    chk_val("be0_pulse_width", 32'(ra), 32'd0);
    run_op(0, 1, 0, 32'h10, 32'h10, 32'h0, 4'h0, lat, rd, err, ra);
    chk_val("rd_after_be0", rd, 32'h12BB_56DD);

    run_op(0, 0, 1, 32'h14, 32'h14, 32'h5555_0000, 4'hF, lat, rd, err, ra);
    run_op(0, 1, 0, 32'h10, 32'h14, 32'h0, 4'h0, lat, rd, err, ra);
    chk_val("rd_frozen_addr", rd, 32'h12BB_56DD);
    run_op(0, 0, 1, 32'h14, 32'h10, 32'h0F0F_0F0F, 4'hF, lat, rd, err, ra);
    run_op(0, 1, 0, 32'h14, 32'h14, 32'h0, 4'h0, lat, rd, err, ra);
    chk_val("wr_frozen_addr", rd, 32'h0F0F_0F0F);
    run_op(0, 1, 0, 32'h10, 32'h10, 32'h0, 4'h0, lat, rd, err, ra);
    chk_val("wr_frozen_other", rd, 32'h12BB_56DD);

    run_op(0, 0, 1, 32'h4, 32'h4, 32'h0000_0004, 4'hF, lat, rd, err, ra);
    run_op(0, 0, 1, 32'h1004, 32'h1004, 32'hCAFE_0001, 4'hF, lat, rd, err, ra);
`ifdef DMEM_ERR_EN
    chk_val("oob_wr_err", 32'(err), 32'd1);
    run_op(0, 1, 0, 32'h4, 32'h4, 32'h0, 4'h0, lat, rd, err, ra);
    chk_val("oob_wr_no_update", rd, 32'h0000_0004);
    chk_val("inb_rd_err", 32'(err), 32'd0);
    run_op(0, 1, 0, 32'h1004, 32'h1004, 32'h0, 4'h0, lat, rd, err, ra);
    chk_val("oob_rd_err", 32'(err), 32'd1);
    chk_val("oob_rd_data", rd, 32'hDEAD_BEEF);
`else
    run_op(0, 1, 0, 32'h4, 32'h4, 32'h0, 4'h0, lat, rd, err, ra);
    chk_val("alias_rd", rd, 32'hCAFE_0001);
    run_op(0, 1, 0, 32'h1004, 32'h1004, 32'h0, 4'h0, lat, rd, err, ra);
    chk_val("alias_rd_hi", rd, 32'hCAFE_0001);
`endif

    // Reset in the middle of a write: pulse suppressed, rdata cleared, write dropped.
    run_op(0, 0, 1, 32'h30, 32'h30, 32'h1111_1111, 4'hF, lat, rd, err, ra);
    set_in(0, 0, 1, 32'h30, 32'h2222_2222, 4'hF);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_val("midrst_resp", 32'(a_resp), 32'd0);
    chk_val("midrst_rdata", a_rdata, 32'd0);
    @(posedge clk); #1;
    set_in(0, 0, 0, 32'h0, 32'h0, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(0, 1, 0, 32'h30, 32'h30, 32'h0, 4'h0, lat, rd, err, ra);
    chk_val("postrst_lat", 32'(lat), 32'd2);
    chk_val("postrst_write_dropped", rd, 32'h1111_1111);

`ifdef DMEM_ERR_EN
    run_op(1, 0, 1, 32'h20, 32'h20, 32'h0000_0012, 4'hF, lat, rd, err, ra);
    run_op(1, 1, 1, 32'h20, 32'h20, 32'h0000_00FF, 4'hF, lat, rd, err, ra);
    chk_val("l1_dual_lat", 32'(lat), 32'd1);
    chk_val("l1_dual_err", 32'(err), 32'd1);
    run_op(1, 1, 0, 32'h20, 32'h20, 32'h0, 4'h0, lat, rd, err, ra);
    chk_val("l1_dual_no_update", rd, 32'h0000_0012);
`else
    run_op(1, 1, 1, 32'h20, 32'h20, 32'h0000_00FF, 4'hF, lat, rd, err, ra);
    chk_val("l1_dual_lat", 32'(lat), 32'd1);
    chk_val("l1_pulse_width", 32'(ra), 32'd0);
    run_op(1, 1, 0, 32'h20, 32'h20, 32'h0, 4'h0, lat, rd, err, ra);
    chk_val("l1_rd_lat", 32'(lat), 32'd1);
    chk_val("l1_dual_as_write", rd, 32'h0000_00FF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
